// File: rtl/gamma_pkg.sv
// Shared widths and FSM state encoding for the gamma LUT bank.
package gamma_pkg;

    localparam int DATA_W    = 8;
    localparam int LUT_DEPTH = 1 << DATA_W;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        PENDING
    } state_t;

endpackage

// File: rtl/gamma_lut_bank_if.sv
// Table-load stream: one entry per beat, framed by sop/eop.
interface gamma_lut_bank_if #(
    parameter int DATA_W = gamma_pkg::DATA_W
);

    logic [DATA_W-1:0] cfg_data;
    logic              cfg_valid;
    logic              cfg_sop;
    logic              cfg_eop;
    logic              cfg_ready;

    modport master (
        output cfg_data,
        output cfg_valid,
        output cfg_sop,
        output cfg_eop,
        input  cfg_ready
    );

    modport slave (
        input  cfg_data,
        input  cfg_valid,
        input  cfg_sop,
        input  cfg_eop,
        output cfg_ready
    );

endinterface

// File: rtl/gamma_lut_ram.sv
// One LUT bank: single write port, two registered read ports.
module gamma_lut_ram #(
    parameter int DATA_W    = gamma_pkg::DATA_W,
    parameter int LUT_DEPTH = gamma_pkg::LUT_DEPTH,
    localparam int AW       = $clog2(LUT_DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr_0,
    output logic [DATA_W-1:0] rdata_0,
    input  logic [AW-1:0]     raddr_1,
    output logic [DATA_W-1:0] rdata_1
);

    logic [DATA_W-1:0] mem [LUT_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata_0 <= mem[raddr_0];
            rdata_1 <= mem[raddr_1];
        end
    end

endmodule

// File: rtl/gamma_lut_bank.sv
// Double-buffered two-channel gamma LUT; shadow bank loads while the
// active bank serves pixels, and the swap happens on the next frame start.
module gamma_lut_bank
    import gamma_pkg::*;
#(
    parameter int DATA_W    = gamma_pkg::DATA_W,
    parameter int LUT_DEPTH = gamma_pkg::LUT_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    gamma_lut_bank_if.slave   cfg,
    input  logic              frame_sop,
    input  logic [DATA_W-1:0] addr_0,
    output logic [DATA_W-1:0] data_0,
    input  logic [DATA_W-1:0] addr_1,
    output logic [DATA_W-1:0] data_1,
    output logic              table_ready,
    output logic              load_error
);

    localparam int AW    = $clog2(LUT_DEPTH);
    localparam int IDX_W = AW + 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(LUT_DEPTH - 1);

    state_t            state, state_n;
    logic [IDX_W-1:0]  idx, idx_n;
    logic              active;
    logic              swap;
    logic              err_n;
    logic              accept;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic              rd_bank;
    logic              sel_q;
    logic              lut_q;
    logic [DATA_W-1:0] addr0_q, addr1_q;
    logic [DATA_W-1:0] a_0, a_1, b_0, b_1;

    assign cfg.cfg_ready = !reset && (state != PENDING);
    assign accept        = cfg.cfg_valid && cfg.cfg_ready;

    always_comb begin
        state_n = state;
        idx_n   = idx;
        err_n   = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        swap    = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept && cfg.cfg_sop) begin
                    wr_en   = 1'b1;
                    idx_n   = IDX_W'(1);
                    state_n = LOAD;
                end
            end
            LOAD: begin
                if (accept) begin
                    if (cfg.cfg_sop) begin
                        err_n = 1'b1;
                        wr_en = 1'b1;
                        idx_n = IDX_W'(1);
                    end else if (cfg.cfg_eop != (idx == LAST)) begin
                        // eop misplaced or missing: drop the whole load
                        err_n   = 1'b1;
                        idx_n   = '0;
                        state_n = IDLE;
                    end else begin
                        wr_en   = 1'b1;
                        wr_addr = idx[AW-1:0];
                        idx_n   = cfg.cfg_eop ? '0 : idx + 1'b1;
                        state_n = cfg.cfg_eop ? PENDING : LOAD;
                    end
                end
            end
            PENDING: begin
                if (frame_sop && !reset) begin
                    swap    = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // The frame_sop read already targets the incoming bank.
    assign rd_bank = active ^ swap;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            idx         <= '0;
            active      <= 1'b0;
            table_ready <= 1'b0;
            load_error  <= 1'b0;
            sel_q       <= 1'b0;
            lut_q       <= 1'b0;
            addr0_q     <= '0;
            addr1_q     <= '0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            load_error <= err_n;
            if (swap) begin
                active      <= ~active;
                table_ready <= 1'b1;
            end
            sel_q   <= rd_bank;
            lut_q   <= table_ready | swap;
            addr0_q <= addr_0;
            addr1_q <= addr_1;
        end
    end

    gamma_lut_ram #(
        .DATA_W    (DATA_W),
        .LUT_DEPTH (LUT_DEPTH)
    ) u_bank_a (
        .clk     (clk),
        .we      (wr_en && active),
        .waddr   (wr_addr),
        .wdata   (cfg.cfg_data),
        .re      (!rd_bank),
        .raddr_0 (addr_0[AW-1:0]),
        .rdata_0 (a_0),
        .raddr_1 (addr_1[AW-1:0]),
        .rdata_1 (a_1)
    );

    gamma_lut_ram #(
        .DATA_W    (DATA_W),
        .LUT_DEPTH (LUT_DEPTH)
    ) u_bank_b (
        .clk     (clk),
        .we      (wr_en && !active),
        .waddr   (wr_addr),
        .wdata   (cfg.cfg_data),
        .re      (rd_bank),
        .raddr_0 (addr_0[AW-1:0]),
        .rdata_0 (b_0),
        .raddr_1 (addr_1[AW-1:0]),
        .rdata_1 (b_1)
    );

    assign data_0 = !lut_q ? addr0_q : (sel_q ? b_0 : a_0);
    assign data_1 = !lut_q ? addr1_q : (sel_q ? b_1 : a_1);

endmodule

// File: tb/tb_gamma_lut_bank.sv
// Directed bench for gamma_lut_bank: identity path, loads, errors, swaps.
module tb_gamma_lut_bank;

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_sop;
    logic [7:0] addr_0, addr_1, data_0, data_1;
    logic       table_ready, load_error;
    int         checks   = 0;
    int         failures = 0;
    int         err_cnt  = 0;
    int         e0;

    always #5 clk = ~clk;

    gamma_lut_bank_if #(.DATA_W(8)) cfg_if ();

    gamma_lut_bank #(
        .DATA_W    (8),
        .LUT_DEPTH (256)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cfg         (cfg_if.slave),
        .frame_sop   (frame_sop),
        .addr_0      (addr_0),
        .data_0      (data_0),
        .addr_1      (addr_1),
        .data_1      (data_1),
        .table_ready (table_ready),
        .load_error  (load_error)
    );

    always @(posedge clk) begin
        if (load_error === 1'b1) err_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] tv(input int kind, input int i);
        case (kind)
            0:       return 8'(255 - i);
            1:       return 8'(i) ^ 8'h5A;
            default: return 8'(i + 3);
        endcase
    endfunction

    task automatic beat(input logic [7:0] d, input logic s, input logic e);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_data  = d;
        cfg_if.cfg_sop   = s;
        cfg_if.cfg_eop   = e;
        step();
    endtask

    task automatic cfg_idle();
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_sop   = 1'b0;
        cfg_if.cfg_eop   = 1'b0;
        cfg_if.cfg_data  = '0;
    endtask

    task automatic load_full(input int kind);
        for (int i = 0; i < 256; i++) beat(tv(kind, i), i == 0, i == 255);
        cfg_idle();
    endtask

    initial begin
        #2ms;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "bench timeout");
    end

    initial begin
        reset     = 1'b1;
        frame_sop = 1'b0;
        addr_0    = 8'h00;
        addr_1    = 8'h00;
        cfg_idle();
        step();
        step();
        check("rst_cfg_ready", cfg_if.cfg_ready, 0);
        check("rst_data_0", data_0, 0);
        check("rst_data_1", data_1, 0);
        check("rst_table_ready", table_ready, 0);
        check("rst_load_error", load_error, 0);

        reset  = 1'b0;
        addr_0 = 8'h40;
        addr_1 = 8'hC0;
        step();
        check("ident_data_0", data_0, 8'h40);
        check("ident_data_1", data_1, 8'hC0);
        check("ident_table_ready", table_ready, 0);
        check("idle_cfg_ready", cfg_if.cfg_ready, 1);

        frame_sop = 1'b1;
        addr_0    = 8'h22;
        step();
        frame_sop = 1'b0;
        check("stray_sop_data", data_0, 8'h22);
        check("stray_sop_ready", table_ready, 0);

        e0 = err_cnt;
        load_full(0);
        addr_0 = 8'h33;
        step();
        check("pend_cfg_ready", cfg_if.cfg_ready, 0);
        check("pend_identity", data_0, 8'h33);
        check("load1_no_err", err_cnt, e0);

        frame_sop = 1'b1;
        addr_0    = 8'h10;
        addr_1    = 8'hFF;
        step();
        frame_sop = 1'b0;
        check("swap1_data_0", data_0, 8'hEF);
        check("swap1_data_1", data_1, 8'h00);
        check("swap1_table_ready", table_ready, 1);
        check("swap1_cfg_ready", cfg_if.cfg_ready, 1);

        e0 = err_cnt;
        for (int i = 0; i <= 100; i++) beat(tv(1, i), i == 0, i == 100);
        cfg_idle();
        check("early_eop_pulse", load_error, 1);
        step();
        check("early_eop_clear", load_error, 0);
        check("early_eop_count", err_cnt, e0 + 1);
        check("early_eop_idle", cfg_if.cfg_ready, 1);
        frame_sop = 1'b1;
        addr_0    = 8'h10;
        step();
        frame_sop = 1'b0;
        check("early_eop_noswap", data_0, 8'hEF);

        e0 = err_cnt;
        for (int i = 0; i < 50; i++) beat(tv(1, i), i == 0, 1'b0);
        load_full(1);
        addr_0 = 8'h10;
        step();
        step();
        check("restart_err_count", err_cnt, e0 + 1);
        check("restart_pending", cfg_if.cfg_ready, 0);
        check("restart_old_tbl", data_0, 8'hEF);
        frame_sop = 1'b1;
        addr_0    = 8'h10;
        addr_1    = 8'h00;
        step();
        frame_sop = 1'b0;
        check("restart_swap_0", data_0, 8'h4A);
        check("restart_swap_1", data_1, 8'h5A);

        for (int i = 0; i < 128; i++) beat(tv(2, i), i == 0, 1'b0);
        cfg_idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midrst_table_ready", table_ready, 0);
        addr_0 = 8'h10;
        step();
        check("midrst_identity", data_0, 8'h10);
        frame_sop = 1'b1;
        addr_0    = 8'h77;
        step();
        frame_sop = 1'b0;
        check("midrst_noswap", data_0, 8'h77);
        check("midrst_still_ident", table_ready, 0);

        load_full(0);
        frame_sop = 1'b1;
        addr_0    = 8'h10;
        step();
        frame_sop = 1'b0;
        check("first_tbl_active", data_0, 8'hEF);
        addr_0 = 8'h20;
        for (int i = 0; i < 256; i++) begin
            beat(tv(2, i), i == 0, i == 255);
            if (i == 128) check("during_load_old", data_0, 8'hDF);
        end
        cfg_idle();
        addr_0 = 8'h30;
        addr_1 = 8'h01;
        step();
        check("pre_swap_old_0", data_0, 8'hCF);
        check("pre_swap_old_1", data_1, 8'hFE);
        frame_sop = 1'b1;
        step();
        frame_sop = 1'b0;
        check("swap_cycle_new_0", data_0, 8'h33);
        check("swap_cycle_new_1", data_1, 8'h04);
        addr_0 = 8'hFF;
        step();
        check("post_swap_new", data_0, 8'h02);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
